// File: rtl/priority_dec.sv
// -----------------------------------------------------------------------------
// priority_dec
//
// Purpose:
//   Registered 2-to-4 one-hot decoder for the output of a 4-input priority
//   encoder (index 0 = highest input D[3], index 3 = lowest input D[0]).
//   It also tracks activity:
//     - a sticky mask of every channel decoded since the last reset or clear
//     - four saturating 8-bit hit counters, one per encoded index
//     - a one-cycle change pulse when a valid code differs from the previous
//       valid code
//
// Ports:
//   clk      in   1  rising-edge clock, only clock domain
//   rst      in   1  synchronous active-high reset, highest priority
//   Y        in   2  encoded index (0 -> D[3] ... 3 -> D[0])
//   valid    in   1  qualifies Y; Y is ignored while low
//   clr      in   1  synchronous clear of the sticky mask and the hit counters
//   cnt_sel  in   2  selects which hit counter drives cnt
//   D        out  4  registered one-hot decode of Y, zero when dv is low
//   dv       out  1  registered copy of valid
//   mask     out  4  sticky OR of decoded codes since the last rst/clr
//   chg      out  1  one-cycle pulse: valid code differs from the last valid code
//   cnt      out  8  combinational read of hit counter cnt_sel
// -----------------------------------------------------------------------------
module priority_dec (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] Y,
    input  logic       valid,
    input  logic       clr,
    input  logic [1:0] cnt_sel,
    output logic [3:0] D,
    output logic       dv,
    output logic [3:0] mask,
    output logic       chg,
    output logic [7:0] cnt
);

    localparam logic [7:0] HC_MAX = 8'd255;

    logic [3:0]       d_q,         d_d;
    logic             dv_q,        dv_d;
    logic [3:0]       mask_q,      mask_d;
    logic             chg_q,       chg_d;
    logic [3:0][7:0]  hc_q,        hc_d;
    logic [1:0]       last_code_q, last_code_d;
    logic             last_vld_q,  last_vld_d;

    logic [3:0]       dec;
    logic [3:0]       mask_base;
    logic [3:0][7:0]  hc_base;

    // Index 0 maps to the MSB, so the one-hot is a right shift of 4'b1000.
    always_comb begin
        dec = 4'b1000 >> Y;
    end

    always_comb begin
        // Clear happens first so a simultaneous valid code lands on a clean
        // mask/counter set rather than being lost.
        mask_base = clr ? 4'b0000 : mask_q;
        hc_base   = clr ? '0      : hc_q;

        d_d         = 4'b0000;
        dv_d        = valid;
        chg_d       = 1'b0;
        mask_d      = mask_base;
        hc_d        = hc_base;
        last_code_d = last_code_q;
        last_vld_d  = last_vld_q;

        if (valid) begin
            d_d         = dec;
            mask_d      = mask_base | dec;
            if (hc_base[Y] != HC_MAX) begin
                hc_d[Y] = hc_base[Y] + 8'd1;
            end
            // The change detector compares against the last valid code only;
            // idle gaps and clr leave the history alone.
            chg_d       = last_vld_q && (Y != last_code_q);
            last_code_d = Y;
            last_vld_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q         <= 4'b0000;
            dv_q        <= 1'b0;
            mask_q      <= 4'b0000;
            chg_q       <= 1'b0;
            hc_q        <= '0;
            last_code_q <= 2'd0;
            last_vld_q  <= 1'b0;
        end else begin
            d_q         <= d_d;
            dv_q        <= dv_d;
            mask_q      <= mask_d;
            chg_q       <= chg_d;
            hc_q        <= hc_d;
            last_code_q <= last_code_d;
            last_vld_q  <= last_vld_d;
        end
    end

    assign D    = d_q;
    assign dv   = dv_q;
    assign mask = mask_q;
    assign chg  = chg_q;
    assign cnt  = hc_q[cnt_sel];

endmodule

// File: tb/tb_priority_dec.sv
module tb_priority_dec;

    logic       clk;
    logic       rst;
    logic [1:0] Y;
    logic       valid;
    logic       clr;
    logic [1:0] cnt_sel;
    logic [3:0] D;
    logic       dv;
    logic [3:0] mask;
    logic       chg;
    logic [7:0] cnt;

    int n_cmp;
    int n_mis;

    priority_dec dut (
        .clk     (clk),
        .rst     (rst),
        .Y       (Y),
        .valid   (valid),
        .clr     (clr),
        .cnt_sel (cnt_sel),
        .D       (D),
        .dv      (dv),
        .mask    (mask),
        .chg     (chg),
        .cnt     (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs, clock once, then settle 1 time unit past the edge.
    task automatic step(input logic r, input logic c, input logic v, input logic [1:0] y);
        rst   = r;
        clr   = c;
        valid = v;
        Y     = y;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string tag, input logic [1:0] sel, input logic [7:0] exp);
        cnt_sel = sel;
        #1;
        chk(tag, cnt, exp);
    endtask

    task automatic chk_out(input string tag, input logic [3:0] d_e, input logic dv_e, input logic chg_e);
        chk({tag, ".D"},   {4'b0, D},   {4'b0, d_e});
        chk({tag, ".dv"},  {7'b0, dv},  {7'b0, dv_e});
        chk({tag, ".chg"}, {7'b0, chg}, {7'b0, chg_e});
    endtask

    initial begin
        logic [3:0] sweep_d [4];
        logic       sweep_c [4];
        logic [7:0] exp_sat;

        n_cmp   = 0;
        n_mis   = 0;
        rst     = 1'b1;
        clr     = 1'b0;
        valid   = 1'b0;
        Y       = 2'd0;
        cnt_sel = 2'd0;

        sweep_d[0] = 4'b1000; sweep_c[0] = 1'b0;
        sweep_d[1] = 4'b0100; sweep_c[1] = 1'b1;
        sweep_d[2] = 4'b0010; sweep_c[2] = 1'b1;
        sweep_d[3] = 4'b0001; sweep_c[3] = 1'b1;

        // Reset with a valid code present: input is discarded.
        step(1, 0, 1, 2'd2);
        step(1, 0, 1, 2'd2);
        chk_out("rst", 4'b0000, 0, 0);
        chk("rst.mask", {4'b0, mask}, 8'h00);
        for (int s = 0; s < 4; s++) chk_cnt("rst.cnt", 2'(s), 8'd0);

        // Decode sweep.
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 2'(i));
            chk_out("sweep", sweep_d[i], 1, sweep_c[i]);
        end
        chk("sweep.mask", {4'b0, mask}, 8'h0F);
        for (int s = 0; s < 4; s++) chk_cnt("sweep.cnt", 2'(s), 8'd1);

        // Idle gap does not clear last code.
        step(1, 0, 0, 2'd0);
        step(0, 0, 1, 2'd1);
        chk_out("gap.first", 4'b0100, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 2'd3);
            chk_out("gap.idle", 4'b0000, 0, 0);
        end
        step(0, 0, 1, 2'd1);
        chk_out("gap.ret", 4'b0100, 1, 0);
        chk_cnt("gap.hc1", 2'd1, 8'd2);
        chk_cnt("gap.hc3", 2'd3, 8'd0);
        chk("gap.mask", {4'b0, mask}, 8'h04);

        // Saturation.
        step(1, 0, 0, 2'd0);
        cnt_sel = 2'd3;
        for (int i = 0; i < 260; i++) begin
            step(0, 0, 1, 2'd3);
            exp_sat = (i >= 254) ? 8'd255 : 8'(i + 1);
            chk("sat.cnt", cnt, exp_sat);
            chk("sat.chg", {7'b0, chg}, 8'h00);
        end
        chk("sat.mask", {4'b0, mask}, 8'h01);
        chk_cnt("sat.hc0", 2'd0, 8'd0);

        // Clear colliding with a valid code.
        step(1, 0, 0, 2'd0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 2'(i));
        chk("clr.pre_mask", {4'b0, mask}, 8'h0F);
        step(0, 1, 1, 2'd2);
        chk_out("clr.coll", 4'b0010, 1, 1);
        chk("clr.coll_mask", {4'b0, mask}, 8'h02);
        chk_cnt("clr.hc0", 2'd0, 8'd0);
        chk_cnt("clr.hc1", 2'd1, 8'd0);
        chk_cnt("clr.hc2", 2'd2, 8'd1);
        chk_cnt("clr.hc3", 2'd3, 8'd0);

        // Clear without valid; history survives the clear.
        step(0, 0, 1, 2'd0);
        chk("clr.mask2", {4'b0, mask}, 8'h0A);
        step(0, 1, 0, 2'd1);
        chk_out("clr.idle", 4'b0000, 0, 0);
        chk("clr.idle_mask", {4'b0, mask}, 8'h00);
        chk_cnt("clr.idle_hc0", 2'd0, 8'd0);
        chk_cnt("clr.idle_hc2", 2'd2, 8'd0);
        step(0, 0, 1, 2'd2);
        chk_out("clr.after", 4'b0010, 1, 1);

        // Reset in the middle of a stream, with clr also high.
        step(1, 0, 0, 2'd0);
        step(0, 0, 1, 2'd0);
        step(0, 0, 1, 2'd1);
        chk_cnt("mid.hc1_pre", 2'd1, 8'd1);
        step(1, 1, 1, 2'd3);
        chk_out("mid.rst", 4'b0000, 0, 0);
        chk("mid.mask", {4'b0, mask}, 8'h00);
        chk_cnt("mid.hc3", 2'd3, 8'd0);
        chk_cnt("mid.hc0", 2'd0, 8'd0);
        step(0, 0, 1, 2'd3);
        chk_out("mid.first", 4'b0001, 1, 0);
        chk_cnt("mid.hc3_post", 2'd3, 8'd1);
        chk("mid.mask_post", {4'b0, mask}, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/priority_dec.md
PRIORITY_DEC -- requirements
Module: priority_dec

Interface
REQ-001 The block SHALL have the following ports (one clock; reset is synchronous and active-high):
  clk      in   1  rising-edge clock, sole clock domain
  rst      in   1  synchronous active-high reset
  Y        in   2  encoded index from the priority encoder (0 = D[3] ... 3 = D[0])
  valid    in   1  Y qualifier; Y ignored when low
  clr      in   1  synchronous clear of sticky mask and hit counters
  cnt_sel  in   2  hit-counter read select
  D        out  4  registered one-hot decode of Y
  dv       out  1  registered copy of valid; qualifies D
  mask     out  4  sticky OR of all decoded D since last rst/clr
  chg      out  1  one-cycle pulse: decoded code differs from previous valid code
  cnt      out  8  hit count of channel selected by cnt_sel

Function
REQ-002 Decode map SHALL be the inverse of the encoder: Y=0 -> D=4'b1000, Y=1 -> 4'b0100, Y=2 -> 4'b0010, Y=3 -> 4'b0001.
REQ-003 D and dv SHALL update one clock after the sampling edge (latency 1); with valid=1, D is the mapped one-hot and dv=1.
REQ-004 With valid=0 at the sampling edge, D SHALL be 4'b0000 and dv SHALL be 0 on the next cycle; Y is don't-care.
REQ-005 D SHALL never have more than one bit set; D is 0 whenever dv=0.
REQ-006 mask SHALL, on each edge with valid=1 and clr=0, become mask | decoded bit; otherwise it holds.
REQ-007 Four 8-bit hit counters hc[0..3] SHALL exist, hc[k] indexed by Y value k; on each edge with valid=1 and clr=0, hc[Y] increments by 1.
REQ-008 Hit counters SHALL saturate at 8'd255; a hit at 255 leaves the counter at 255, no wrap.
REQ-009 cnt SHALL be a combinational read of hc[cnt_sel]; no added latency.
REQ-010 clr=1 with valid=0 SHALL set mask=0 and all hc=0 on the next cycle; D/dv/chg follow normal rules.
REQ-011 clr=1 and valid=1 on the same edge SHALL clear-then-apply: mask = decoded bit only, hc[Y]=1, all other hc=0.
REQ-012 The block SHALL hold a last-code register and a last-valid flag, both loaded on every edge with valid=1; clr does not affect them.
REQ-013 chg SHALL be 1 the cycle after an edge where valid=1, last-valid flag=1 and Y != last code; otherwise chg=0.
REQ-014 First valid code after reset SHALL produce chg=0; repeated identical codes SHALL produce chg=0; gaps with valid=0 do not clear the last code.
REQ-015 rst SHALL take precedence over clr and valid on the same edge.

Reset
REQ-016 On an edge with rst=1: D=4'b0000, dv=0, mask=4'b0000, chg=0, all hc=0, last-valid flag=0, last code=0; cnt then reads 0 for every cnt_sel.
REQ-017 Reset asserted mid-stream SHALL discard the input sampled on that edge; no counter or mask update occurs.
REQ-018 Outputs SHALL be at reset values from the cycle after the first rst edge until the cycle after the first edge with rst=0.

Verification
REQ-019 Reset: rst=1, valid=1, Y=2 for 1 cycle -> next cycle D=0000, dv=0, mask=0000, chg=0, cnt=0 for all cnt_sel.
REQ-020 Decode sweep: valid=1, Y=0,1,2,3 on successive cycles -> D=1000,0100,0010,0001 one cycle later each, dv=1, chg=0,1,1,1, final mask=1111, hc[0..3]=1 each.
REQ-021 Idle gap: valid=1 Y=1, then valid=0 for 3 cycles with Y=3, then valid=1 Y=1 -> D=0000/dv=0 during gap, chg=0 on return, hc[1]=2, hc[3]=0.
REQ-022 Saturation: valid=1 Y=3 for 260 cycles, cnt_sel=3 -> cnt reaches 255 and stays 255, mask=0001, chg=0 throughout.
REQ-023 Clear collision: after mask=1111, assert clr=1 with valid=1 Y=2 -> next cycle mask=0010, hc[2]=1, hc[0],hc[1],hc[3]=0, D=0010, dv=1.
REQ-024 Reset mid-operation: stream Y=0,1 then rst=1 with valid=1 Y=3 -> no hc[3] increment; after release, first valid Y=3 gives chg=0, D=0001.
